// File: rtl/sdram_arb_pkg.sv
// Shared widths, port-id type and the round-robin search used by the SDRAM arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W          = 26;
  localparam int DATA_W          = 16;
  localparam int DEF_BURST_BEATS = 8;
  localparam int MAX_PORTS       = 8;
  localparam int PORT_ID_W       = 3;

  typedef logic [PORT_ID_W-1:0] port_id_t;

  typedef struct packed {
    logic     found;
    port_id_t id;
  } grant_t;

  // Walks downward so the last hit written is the first eligible port at or after start.
  function automatic grant_t rr_first(input logic [MAX_PORTS-1:0] elig,
                                      input port_id_t             start,
                                      input int unsigned          nports);
    grant_t g;
    int     idx;
    g = '0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (i < int'(nports)) begin
        idx = (int'(start) + i) % int'(nports);
        if (elig[idx[2:0]]) begin
          g.found = 1'b1;
          g.id    = idx[2:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO holding the owner of each read whose burst is still outstanding.
// Zero-latency head; push while full and pop while empty are ignored.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  port_id_t push_dat_i,
  input  logic     pop_i,
  output port_id_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  port_id_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM command port; steers read bursts back to their owner.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest) instead of round-robin.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int TAG_DEPTH   = 2,
  parameter int BURST_BEATS = DEF_BURST_BEATS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_write,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [NUM_PORTS-1:0]        rsp_val,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data_write,
  input  logic                        mem_cmd_ready,
  input  logic [DATA_W-1:0]           mem_data_read,
  input  logic                        mem_data_read_val,
  output logic                        tag_err
);

  localparam int BW = $clog2(BURST_BEATS);

  logic [MAX_PORTS-1:0] rd_w, wr_w, elig, ready_w, rsp_oh;
  logic [ADDR_W-1:0]    addr_a [MAX_PORTS];
  logic [DATA_W-1:0]    wdat_a [MAX_PORTS];
  grant_t               gnt;
  port_id_t             sel, tag_head;
  logic                 accept, tag_full, tag_empty, beat_vld, pop;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 tag_err_q, tag_err_d;

  assign rd_w = MAX_PORTS'(req_read);
  assign wr_w = MAX_PORTS'(req_write);

  for (genvar p = 0; p < MAX_PORTS; p++) begin : g_port
    if (p < NUM_PORTS) begin : g_used
      assign addr_a[p] = req_addr[ADDR_W*p +: ADDR_W];
      assign wdat_a[p] = req_data_write[DATA_W*p +: DATA_W];
    end else begin : g_pad
      assign addr_a[p] = '0;
      assign wdat_a[p] = '0;
    end
  end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  port_id_t rr_q;
  assign rr_q = '0;
`else
  port_id_t rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = (int'(gnt.id) == NUM_PORTS - 1) ? '0 : gnt.id + 3'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= '0;
    else        rr_q <= rr_d;
  end
`endif

  // A port asserting both read and write is a read, so it is also blocked when full.
  assign elig   = tag_full ? (wr_w & ~rd_w) : (rd_w | wr_w);
  assign gnt    = rr_first(elig, rr_q, NUM_PORTS);
  assign accept = reset & mem_cmd_ready & gnt.found;
  assign sel    = accept ? gnt.id : rr_q;

  assign mem_read       = accept & rd_w[gnt.id];
  assign mem_write      = accept & ~rd_w[gnt.id] & wr_w[gnt.id];
  assign mem_addr       = addr_a[sel];
  assign mem_data_write = wdat_a[sel];
  assign ready_w        = accept ? (MAX_PORTS'(1) << gnt.id) : '0;
  assign req_ready      = ready_w[NUM_PORTS-1:0];

  sdram_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (mem_read),
    .push_dat_i (gnt.id),
    .pop_i      (pop),
    .head_o     (tag_head),
    .full_o     (tag_full),
    .empty_o    (tag_empty)
  );

  assign beat_vld = mem_data_read_val & ~tag_empty;
  assign pop      = beat_vld & (beat_q == BW'(BURST_BEATS - 1));
  assign rsp_data = mem_data_read;
  assign rsp_oh   = (reset & beat_vld) ? (MAX_PORTS'(1) << tag_head) : '0;
  assign rsp_val  = rsp_oh[NUM_PORTS-1:0];
  assign tag_err  = tag_err_q;

  always_comb begin
    beat_d    = beat_q;
    tag_err_d = tag_err_q | (mem_data_read_val & tag_empty);
    if (beat_vld) beat_d = pop ? '0 : beat_q + BW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q    <= '0;
      tag_err_q <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      tag_err_q <= tag_err_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench with a return-beat scoreboard for sdram_arbiter (4 ports, 2 tags, 8 beats).
module tb_sdram_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_read, req_write, req_ready, rsp_val;
  logic [103:0] req_addr;
  logic [63:0]  req_data_write;
  logic [15:0]  rsp_data, mem_data_write, mem_data_read;
  logic         mem_read, mem_write, mem_cmd_ready, mem_data_read_val, tag_err;
  logic [25:0]  mem_addr;

  sdram_arbiter dut (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_data_write(req_data_write), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_val(rsp_val), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data_write(mem_data_write), .mem_cmd_ready(mem_cmd_ready),
    .mem_data_read(mem_data_read), .mem_data_read_val(mem_data_read_val), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  val;
    logic [15:0] dat;
  } beat_t;

  beat_t exp_q[$];
  int    errs = 0, checks = 0;
  int    ret_left = 0, beat_k = 0, burst_no = 0, rd_no = 0;
  bit    stray = 0, cont = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] wd(input int p);
    return 16'(16'h1110 * (p + 1));
  endfunction

  // Memory side: drives the next return beat (or a stray beat), then lets logic settle.
  task automatic pre();
    if (ret_left > 0) begin
      mem_data_read_val = 1'b1;
      mem_data_read     = 16'hA000 + 16'(burst_no * 8 + beat_k);
      ret_left--;
      beat_k++;
      if (beat_k == 8) begin
        beat_k = 0;
        burst_no++;
      end
    end else if (stray) begin
      mem_data_read_val = 1'b1;
      mem_data_read     = 16'h5555;
    end else begin
      mem_data_read_val = 1'b0;
    end
    #1;
  endtask

  // Checks grant and return path, queues expected beats for granted reads, then clocks.
  task automatic post(input logic [3:0] exp_rdy);
    beat_t e;
    chk("req_ready", req_ready, exp_rdy);
    if (mem_data_read_val) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e.val = 4'b0;
        e.dat = mem_data_read;
      end
      chk("rsp_val", rsp_val, e.val);
      chk("rsp_data", rsp_data, e.dat);
    end else begin
      chk("rsp_idle", rsp_val, 4'b0);
    end
    for (int p = 0; p < 4; p++) begin
      if (exp_rdy[p] && req_read[p]) begin
        for (int k = 0; k < 8; k++) begin
          e.val = 4'(1 << p);
          e.dat = 16'hA000 + 16'(rd_no * 8 + k);
          exp_q.push_back(e);
        end
        rd_no++;
      end
    end
    @(posedge clk);
    #1;
    if (!cont) begin
      req_read  = req_read & ~exp_rdy;
      req_write = req_write & ~exp_rdy;
    end
  endtask

  task automatic cyc(input logic [3:0] exp_rdy);
    pre();
    post(exp_rdy);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_read = '0;
    req_write = '0;
    mem_data_read_val = 1'b0;
    exp_q.delete();
    ret_left = 0; beat_k = 0; burst_no = 0; rd_no = 0;
    stray = 0; cont = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    mem_cmd_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      req_addr[26*p +: 26]       = 26'(26'h0100000 * p + 26'h55);
      req_data_write[16*p +: 16] = wd(p);
    end
    req_addr[52 +: 26] = 26'h0012345;
    req_read = 4'hF;
    req_write = 4'hF;
    mem_data_read_val = 1'b1;
    mem_data_read = 16'h1234;
    #1 reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 4'b0);
    chk("rst_rsp_val", rsp_val, 4'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_tag_err", tag_err, 1'b0);
    do_reset();

    // Single read from port 2, then its 8-beat burst; a following beat must be stray.
    req_read = 4'b0100;
    pre();
    chk("t1_mem_read", mem_read, 1'b1);
    chk("t1_mem_write", mem_write, 1'b0);
    chk("t1_mem_addr", mem_addr, 26'h0012345);
    post(4'b0100);
    ret_left = 8;
    repeat (8) cyc(4'b0);
    stray = 1;
    cyc(4'b0);
    stray = 0;
    chk("t1_fifo_empty_err", tag_err, 1'b1);
    do_reset();

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    cont = 1;
    req_write = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      pre();
      chk("fp_wdata", mem_data_write, wd(0));
      post(4'b0001);
    end
    cont = 0;
    req_write = '0;
`else
    // Every port writes continuously: grants rotate, a not-ready cycle holds the pointer.
    cont = 1;
    req_write = 4'hF;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        mem_cmd_ready = 1'b0;
        pre();
        chk("nordy_mem_write", mem_write, 1'b0);
        post(4'b0);
        mem_cmd_ready = 1'b1;
      end
      pre();
      chk("rr_mem_write", mem_write, 1'b1);
      chk("rr_wdata", mem_data_write, wd(i % 4));
      post(4'(1 << (i % 4)));
    end
    cont = 0;
    req_write = '0;
`endif

    // Two reads fill the tag FIFO; port 3's read waits until port 0's burst drains.
    req_read = 4'b0011;
    cyc(4'b0001);
    cyc(4'b0010);
    req_read[3] = 1'b1;
    cyc(4'b0);
    req_write[2] = 1'b1;
    pre();
    chk("full_mem_write", mem_write, 1'b1);
    chk("full_mem_read", mem_read, 1'b0);
    post(4'b0100);
    ret_left = 8;
    repeat (8) cyc(4'b0);
    cyc(4'b1000);
    ret_left = 16;
    repeat (16) cyc(4'b0);

    // Write from port 0 accepted while port 1's burst streams back.
    req_read = 4'b0010;
    cyc(4'b0010);
    ret_left = 8;
    req_data_write[15:0] = 16'hBEEF;
    req_write = 4'b0001;
    pre();
    chk("ovl_mem_write", mem_write, 1'b1);
    chk("ovl_mem_read", mem_read, 1'b0);
    chk("ovl_wdata", mem_data_write, 16'hBEEF);
    post(4'b0001);
    repeat (7) cyc(4'b0);

    // Stray beat sets the sticky error; only reset clears it.
    chk("tag_err_clear", tag_err, 1'b0);
    stray = 1;
    pre();
    chk("stray_rsp_val", rsp_val, 4'b0);
    post(4'b0);
    stray = 0;
    chk("tag_err_set", tag_err, 1'b1);
    cyc(4'b0);
    chk("tag_err_sticky", tag_err, 1'b1);
    req_read = 4'hF;
    mem_data_read_val = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst2_tag_err", tag_err, 1'b0);
    chk("rst2_req_ready", req_ready, 4'b0);
    chk("rst2_rsp_val", rsp_val, 4'b0);
    chk("rst2_mem_read", mem_read, 1'b0);
    chk("rst2_mem_write", mem_write, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller command port among NUM_PORTS requesters using round-robin arbitration.
- Forwards the granted port's read/write, address and write data to the controller.
- Records the owner of each accepted read in a small tag FIFO. Steers each returning 8-beat read burst back to that owner.
- Sits between SoC masters (CPU, video fetch, DMA) and the SDRAM controller.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..8).
- TAG_DEPTH, 2, maximum number of reads accepted whose bursts have not fully returned (power of 2, ≥2).
- BURST_BEATS, 8, data beats returned per read command.

Ports:
- clk  in  1  system clock; the SDRAM controller runs on the same clock.
- reset  in  1  asynchronous, active-low reset.
- req_read  in  NUM_PORTS  per-port read request.
- req_write  in  NUM_PORTS  per-port write request.
- req_addr  in  NUM_PORTS*26  per-port address {chip, bank[1:0], row[12:0], col[9:0]}; port p occupies bits [26p+25:26p].
- req_data_write  in  NUM_PORTS*16  per-port write word.
- req_ready  out  NUM_PORTS  one-hot; high on the cycle the port's command is accepted.
- rsp_data  out  16  read data, broadcast to all ports.
- rsp_val  out  NUM_PORTS  one-hot; read beat valid for that port.
- mem_read  out  1  to the controller's read input.
- mem_write  out  1  to the controller's write input.
- mem_addr  out  26  to the controller's address input.
- mem_data_write  out  16  to the controller's write data input.
- mem_cmd_ready  in  1  from the controller; a command is accepted on the rising edge where this is high and read or write is high.
- mem_data_read  in  16  from the controller's read data output.
- mem_data_read_val  in  1  from the controller's read-valid output.
- tag_err  out  1  sticky: a beat arrived with no outstanding read.

Behaviour:
- Reset (reset=0, asynchronous):
  - rr_ptr=0, tag FIFO empty, beat_cnt=0, tag_err=0.
  - req_ready, rsp_val, mem_read and mem_write are forced to 0 while reset is low.
- Request hold rule:
  - A port holds its request, address and data stable until it sees req_ready.
  - If both read and write are set, the port is treated as a read; the write is ignored for that command.
- Eligibility:
  - A port is eligible when it requests.
  - When the tag FIFO is full, read requests are ineligible; writes stay eligible.
- Grant (combinational, zero added latency):
  - When mem_cmd_ready=1, g = the first eligible port searching from rr_ptr upward, with wrap.
  - mem_read/mem_write/mem_addr/mem_data_write are driven from port g; req_ready[g]=1.
  - With no eligible port, or mem_cmd_ready=0: mem_read=mem_write=0, req_ready=0, and mem_addr/mem_data_write hold port rr_ptr's values (don't-care).
- Pointer update: on an accept, rr_ptr <= (g+1) mod NUM_PORTS on the next edge. With no accept, rr_ptr holds.
- Tag push: an accepted read pushes g into the tag FIFO at that edge.
- Return path:
  - rsp_data = mem_data_read (pass-through).
  - rsp_val[head tag] = mem_data_read_val while the FIFO is non-empty; all other rsp_val bits are 0.
  - Each valid beat increments beat_cnt (3 bits for 8 beats).
  - On beat BURST_BEATS-1: beat_cnt wraps to 0 and the FIFO pops.
- Simultaneous push and pop in one cycle:
  - Both take effect; occupancy is unchanged.
  - A push into a full FIFO cannot occur, because reads are gated off when full.
  - A pop making room makes reads eligible the following cycle, not the same cycle.
- Stray beat: mem_data_read_val=1 with the FIFO empty → beat dropped, all rsp_val=0, tag_err<=1. tag_err is cleared only by reset.
- Mid-burst reset: all tracking is lost and the controller is reset with the arbiter. No recovery of partial bursts.
- Writes do not touch the tag FIFO.

Optional Feature:
- SDRAM_ARB_FIXED_PRIO_EN defined:
  - Priority is fixed, port 0 highest; g = the lowest-index eligible port.
  - rr_ptr is removed, or tied to 0.
- Not defined: round-robin as above.

Decomposition:
- Package sdram_arb_pkg holds:
  - ADDR_W=26, DATA_W=16.
  - Default BURST_BEATS=8.
  - Typedef port_id_t of width $clog2(NUM_PORTS), with a maximum of 3 bits.
  - A function for the round-robin first-eligible search.
- Sub-module sdram_arb_tag_fifo: synchronous FIFO of port_id_t, depth TAG_DEPTH, with push/pop/full/empty/head and asynchronous active-low reset.

Test Plan:
- Single read: port 2 reads addr 0x0012345 with mem_cmd_ready=1 → req_ready=0b0100 for one cycle, mem_read=1, mem_addr=0x0012345. The model returns 8 beats 0xA000..0xA007 → rsp_val[2] high for exactly 8 cycles with matching data, FIFO empty afterwards.
- Round-robin: all 4 ports write continuously with mem_cmd_ready=1 every cycle → grant order 0,1,2,3,0,1… with no port granted twice before all others are granted once.
- Tag-full stall:
  - Ports 0 and 1 read back-to-back with no beats returned → FIFO full.
  - Port 3's read is held off while port 2's write is granted.
  - After 8 beats for port 0 → port 3's read is granted the following cycle, and later beats go to port 1, then port 3.
- Overlap: port 1's read burst is returning while port 0's write is accepted in the same cycles → write forwarded with mem_data_write=0xBEEF, rsp_val[1] beats uninterrupted.
- Stray beat: mem_data_read_val=1 with the FIFO empty → rsp_val=0, tag_err=1 and it stays set; reset low → tag_err=0, all outputs 0.
- With SDRAM_ARB_FIXED_PRIO_EN: ports 0 and 3 request continuously → port 0 is always granted and port 3 is never granted.
